// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell modulo counter.
// Holds the JK truth-table encodings and the minimum-width helper.
package jk_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Bits needed to hold the values 0 .. modulus-1.
   function automatic int min_width(input int modulus);
      return (modulus <= 2) ? 1 : $clog2(modulus);
   endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop cell with synchronous active-low reset.
module jk_ff_sync
   import jk_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic J,
   input  logic K,
   output logic Q
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= 1'b0;
      end else begin
         case ({J, K})
            JK_HOLD:   r_q <= r_q;
            JK_RESET:  r_q <= 1'b0;
            JK_SET:    r_q <= 1'b1;
            JK_TOGGLE: r_q <= ~r_q;
            default:   r_q <= r_q;
         endcase
      end
   end

   assign Q = r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from a bank of JK cells driven in toggle form.
// Next state is computed first; each cell toggles where it differs from the current count.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_tog;
   logic             w_wrap_nx;
   logic             r_wrap;

   generate
      if (WIDTH < min_width(MODULUS)) begin : g_width_check
         $error("jk_mod_counter: WIDTH too small for MODULUS");
      end
   endgenerate

   // Wrap is detected before stepping, so the step never leaves WIDTH bits.
   always_comb begin
      w_next    = w_q;
      w_wrap_nx = 1'b0;
      if (load) begin
         w_next = (din > LP_MAX) ? LP_MAX : din;
      end else if (en) begin
         if (w_q > LP_MAX) begin
            w_next    = '0;
            w_wrap_nx = 1'b1;
         end else if (up) begin
            if (w_q == LP_MAX) begin
               w_next    = '0;
               w_wrap_nx = 1'b1;
            end else begin
               w_next = w_q + 1'b1;
            end
         end else begin
            if (w_q == '0) begin
               w_next    = LP_MAX;
               w_wrap_nx = 1'b1;
            end else begin
               w_next = w_q - 1'b1;
            end
         end
      end
   end

   assign w_tog = w_q ^ w_next;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         jk_ff_sync u_cell (
            .clk   (clk),
            .reset (reset),
            .J     (w_tog[gi]),
            .K     (w_tog[gi]),
            .Q     (w_q[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_nx;
      end
   end

   assign tc   = en & ((up & (w_q == LP_MAX)) | (~up & (w_q == '0)));
   assign q    = w_q;
   assign wrap = r_wrap;

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter whose state bits are held in JK flip-flop cells. It is the stage that drives the J/K inputs of the flip-flop bank and consumes its Q outputs. Each cycle it computes per-bit toggle requests from the current count and the commanded operation. It provides the W7 lab chain with a reusable counting element: a BCD digit by default, any modulus by parameter.

## Interface
- WIDTH, 4: counter width in bits; must satisfy 2^WIDTH >= MODULUS.
- MODULUS, 10: count range 0 .. MODULUS-1; must be >= 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count (the Q outputs of the JK cells).
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap-around step.

## Operation
- Priority at each rising edge: reset low > load > en > hold.
- reset low: q <= 0, wrap <= 0.
- load high:
  - If din < MODULUS, q <= din.
  - If din >= MODULUS, q <= MODULUS-1 (saturating clamp).
  - wrap <= 0. en and up are ignored.
- en high, up high: q <= q+1, except q == MODULUS-1 gives q <= 0 and wrap <= 1.
- en high, up low: q <= q-1, except q == 0 gives q <= MODULUS-1 and wrap <= 1.
- Otherwise q holds and wrap <= 0.
- tc = en & ((up & q == MODULUS-1) | (~up & q == 0)). No dependence on load or reset.
- Out-of-range state: if q >= MODULUS, the next enabled step in either direction loads 0 and asserts wrap. This state is reachable only by fault, never by legal operation.
- Cell drive: the next-state value is computed first. Each bit i is then driven with J_i = K_i = q_i XOR next_i (toggle form). For the reset cycle, J/K are don't-care because the cell's own reset dominates.
- Arithmetic: compare and step at WIDTH bits. No intermediate result exceeds WIDTH bits, because wrap is detected before the step.

## Timing
- Count latency: 1 cycle. q reflects a command on the edge at which it is sampled.
- wrap is valid in the cycle after the wrapping edge and lasts exactly 1 cycle per wrap event.
- wrap is re-asserted on every consecutive wrap, e.g. MODULUS=2 counting continuously.
- tc is combinational from q, en and up, with no register stage. Cascade the next digit with that digit's en = this digit's tc.
- Simultaneous reset low and load high: reset wins.
- Simultaneous load and en: load wins, and no wrap is generated.
- Reset asserted mid-count: q = 0 at the next edge regardless of en/up; a pending wrap pulse is cleared.
- Reset deasserted: first possible count edge is the next rising clk.

## Structure
- Shared package jk_pkg holds:
  - the localparam helper for the minimum WIDTH of a MODULUS (clog2);
  - the JK truth-table encoding constants (HOLD=00, RESET=01, SET=10, TOGGLE=11), reused by the cell and the bench.
- One sub-module: jk_ff_sync, a single JK cell with synchronous active-low reset.
  - Instantiated WIDTH times via generate.
  - Ports: clk, reset, J, K, Q.
- Next-state, clamp, tc and toggle logic live in the top module. The wrap register is the only flop outside the cells.

## Test plan
- Reset: reset=0 for 2 cycles with en=1, up=1 -> q=0, wrap=0. Release reset -> q=1 one cycle later.
- Up wrap: en=1, up=1 from q=0 for 10 cycles -> q steps 1..9 then 0.
  - tc=1 while q=9.
  - wrap=1 exactly in the cycle q first reads 0.
- Down wrap: load din=0, then en=1, up=0 -> q=9 next cycle with wrap=1, then 8, 7.
- Load and clamp:
  - din=6 with load=1, en=1 -> q=6, no step.
  - din=13 with load=1 -> q=9.
- Priority:
  - reset=0 together with load=1, din=5 -> q=0.
  - At q=9, load=1 together with en=1, up=1 -> q=din, wrap=0.
- Cascade: two instances, with units.tc driving tens.en. Run 99 enabled cycles from 00 -> tens.q=9, units.q=9. One more cycle -> 00, with both wrap pulses high in that cycle.
